// File: rtl/not_8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : not_8_pkg
// Purpose  : Shared gate-library constants for the not_8 inverter slice.
// Revision : 1.0 - initial release
// ============================================================================
package not_8_pkg;

    // Datapath width used when the instantiating block does not override it.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Reset image of the registered result.
    localparam logic C_FQ_RESET = 1'b0;

endpackage : not_8_pkg
`default_nettype wire

// File: rtl/not_8_not1.sv
`default_nettype none
// ============================================================================
// Module   : not1
// Purpose  : Single-bit inverter cell; one instance per result bit.
// Revision : 1.0 - initial release
// ============================================================================
module not1 (
    output logic y,
    input  logic a
);

    // Pure combinational inversion, no state.
    assign y = ~a;

endmodule : not1
`default_nettype wire

// File: rtl/not_8.sv
`default_nettype none
// ============================================================================
// Module   : not_8
// Purpose  : WIDTH-bit inverter built from per-bit not1 cells, with a
//            capture register, a sticky valid flag and a one-cycle change flag.
// Revision : 1.0 - initial release
// ============================================================================
module not_8
    import not_8_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic             en,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] F_q,
    output logic             valid,
    output logic             chg
);

    // One inverter per bit; the bits never interact.
    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            not1 u_not1 (
                .y (F[i]),
                .a (A[i])
            );
        end
    endgenerate

    // All state: reset wins over enable; the register is loaded from the
    // combinational result F so both paths always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            F_q   <= {WIDTH{C_FQ_RESET}};
            valid <= 1'b0;
            chg   <= 1'b0;
        end else if (en) begin
            F_q   <= F;
            valid <= 1'b1;
            chg   <= (F != F_q);
        end else begin
            chg   <= 1'b0;
        end
    end

endmodule : not_8
`default_nettype wire

// File: tb/tb_not_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_not_8
// Purpose  : Self-checking bench for not_8 with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_not_8;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] fq;
        logic         valid;
        logic         chg;
        logic [W-1:0] f;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic         en;
    logic [W-1:0] F;
    logic [W-1:0] F_q;
    logic         valid;
    logic         chg;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference state: what the captured result should be, from the rules.
    logic [W-1:0] m_fq;
    logic         m_valid;

    not_8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .en    (en),
        .F     (F),
        .F_q   (F_q),
        .valid (valid),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, check the combinational
    // output, then predict the registered outputs after the coming rising edge.
    task automatic step(input logic r, input logic e, input logic [W-1:0] a);
        exp_t x;
        logic [W-1:0] inv;
        @(negedge clk);
        rst = r;
        en  = e;
        A   = a;
        #1;
        inv = W'(255) - a;
        chk("F_comb", 32'(F), 32'(inv));
        if (r) begin
            m_fq    = '0;
            m_valid = 1'b0;
            x.chg   = 1'b0;
        end else if (e) begin
            x.chg   = (inv != m_fq);
            m_fq    = inv;
            m_valid = 1'b1;
        end else begin
            x.chg   = 1'b0;
        end
        x.fq    = m_fq;
        x.valid = m_valid;
        x.f     = inv;
        sb.push_back(x);
    endtask

    // Monitor: after each rising edge, compare against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("F_q",   32'(F_q),   32'(x.fq));
                chk("valid", 32'(valid), 32'(x.valid));
                chk("chg",   32'(chg),   32'(x.chg));
                chk("F_mon", 32'(F),     32'(x.f));
            end
        end
    end

    // Stimulus.
    initial begin
        logic [W-1:0] sweep [6];
        int budget;
        sweep[0] = 8'h00; sweep[1] = 8'hFF; sweep[2] = 8'h00;
        sweep[3] = 8'hBF; sweep[4] = 8'h59; sweep[5] = 8'hAA;

        rst = 1'b1;
        en  = 1'b1;
        A   = 8'h5A;
        m_fq    = '0;
        m_valid = 1'b0;

        // Reset held over two edges with capture requested.
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'h5A);

        // Combinational sweep with the register idle.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            A = sweep[i];
            #10;
            chk("sweep_F", 32'(F), 32'(8'hFF ^ sweep[i]));
        end

        // First capture, then the same value again.
        step(1'b0, 1'b1, 8'h59);
        step(1'b0, 1'b1, 8'h59);

        // Hold while the operand moves.
        step(1'b0, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'hAA);

        // Same-value capture straight after reset.
        step(1'b1, 1'b0, 8'h12);
        step(1'b0, 1'b1, 8'hFF);

        // Reset beats enable, then a real change.
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        // Randomized traffic, including occasional resets and repeated operands.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a;
            logic r;
            logic e;
            r = ($urandom_range(0, 19) == 0);
            e = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                2:       a = A;
                default: a = W'($urandom);
            endcase
            step(r, e, a);
        end

        // Drain the scoreboard with a bounded wait.
        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_not_8
`default_nettype wire
